// File: rtl/nibble_seq_pkg.sv
// Shared definitions for the nibble-serial add/subtract sequencer and its datapath.
package nibble_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int NIBBLE_W = 4;

    // A single-nibble operand still needs a one-bit index register.
    function automatic int idx_width(input int nib);
        return (nib > 1) ? $clog2(nib) : 1;
    endfunction

endpackage

// File: rtl/full_adder.sv
// Nibble-wide ripple-carry adder used as the sequencer's only arithmetic element.
module full_adder
    import nibble_seq_pkg::*;
(
    input  logic [NIBBLE_W-1:0] x,
    input  logic [NIBBLE_W-1:0] y,
    input  logic                cin,
    output logic [NIBBLE_W-1:0] z,
    output logic                cout
);

    logic carry;

    always_comb begin
        z     = '0;
        carry = cin;
        for (int i = 0; i < NIBBLE_W; i++) begin
            z[i]  = x[i] ^ y[i] ^ carry;
            carry = (x[i] & y[i]) | (carry & (x[i] ^ y[i]));
        end
        cout = carry;
    end

endmodule

// File: rtl/nibble_add_sequencer.sv
// Multi-precision add/subtract controller: one nibble per clock, LSB nibble first,
// with a registered carry between nibbles and valid/ready handshakes on both sides.
module nibble_add_sequencer
    import nibble_seq_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             result_valid,
    input  logic             result_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    localparam int NIB  = WIDTH / NIBBLE_W;
    localparam int IDXW = idx_width(NIB);
    localparam logic [IDXW-1:0] LAST = IDXW'(NIB - 1);

    state_t              state, state_next;
    logic [WIDTH-1:0]    a_reg, b_reg, sum_reg;
    logic                carry;
    logic [IDXW-1:0]     k;
    logic [NIBBLE_W-1:0] nib_a, nib_b, nib_z;
    logic                nib_cout;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start_valid)  state_next = RUN;
            RUN:     if (k == LAST)    state_next = DONE;
            DONE:    if (result_ready) state_next = IDLE;
            default:                   state_next = IDLE;
        endcase
    end

    // Select the current nibble of each operand; b_reg already holds the inverted
    // operand for subtraction so the adder never needs to know the operation.
    always_comb begin
        nib_a = '0;
        nib_b = '0;
        for (int i = 0; i < NIB; i++) begin
            if (k == IDXW'(i)) begin
                nib_a = a_reg[i*NIBBLE_W +: NIBBLE_W];
                nib_b = b_reg[i*NIBBLE_W +: NIBBLE_W];
            end
        end
    end

    full_adder u_adder (
        .x    (nib_a),
        .y    (nib_b),
        .cin  (carry),
        .z    (nib_z),
        .cout (nib_cout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg   <= '0;
            b_reg   <= '0;
            sum_reg <= '0;
            carry   <= 1'b0;
            k       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_valid) begin
                        a_reg   <= a;
                        b_reg   <= sub ? ~b : b;
                        carry   <= sub ? 1'b1 : cin;
                        sum_reg <= '0;
                        k       <= '0;
                    end
                end
                RUN: begin
                    for (int i = 0; i < NIB; i++) begin
                        if (k == IDXW'(i)) sum_reg[i*NIBBLE_W +: NIBBLE_W] <= nib_z;
                    end
                    carry <= nib_cout;
                    if (k != LAST) k <= k + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign start_ready  = (state == IDLE);
    assign result_valid = (state == DONE);
    assign sum          = sum_reg;
    assign cout         = carry;
    assign overflow     = (a_reg[WIDTH-1] == b_reg[WIDTH-1]) && (sum_reg[WIDTH-1] != a_reg[WIDTH-1]);

endmodule
